load_store_unit: RTL and testbench

- MEM-stage initiator for the RV32I core's word-organised data memory (`DataMemory`).
  - Accepts byte-addressed load/store requests from the pipeline.
  - Converts them to word-indexed `io_mem_*` accesses.
  - Performs read-modify-write for SB/SH, because the memory has no byte enables.
  - Sign/zero-extends load data and flags misaligned or illegal accesses.
- Sits between the EX/MEM pipeline register and `DataMemory`.
- Deasserts `io_req_ready` to stall the pipeline while busy.

---
 rtl/rv32_lsu_pkg.sv | 41 ++++
 rtl/lsu_load_align.sv | 30 +++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
// Holds the funct3 codes, access sizes, lane helpers and FSM state encoding.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] gives the access size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] LANE_0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_ERR    = 3'd5
  } lsu_state_e;

  function automatic logic f3_load_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~addr_lo[0];
      SZ_W:    return addr_lo == LANE_0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it
// according to the load funct3.
module lsu_load_align
  import rv32_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{addr_lo, 3'b000} +: 8];
  assign lane_h = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_BU:   result = {24'h0, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_HU:   result = {16'h0, lane_h};
      F3_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-organised data memory without
// byte enables; sub-word stores are done as read-modify-write.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | ready for a request; response pulse shows here
//   ST_RD     | load read cycle, extended data registered
//   ST_WR     | full-word store write cycle
//   ST_RMW_RD | read old word, merge store byte/half
//   ST_RMW_WR | write merged word
//   ST_ERR    | misaligned/illegal, no memory access
module load_store_unit
  import rv32_lsu_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_req_load,
  input  logic        io_req_store,
  input  logic [2:0]  io_req_funct3,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  output logic        io_resp_valid,
  output logic        io_resp_err,
  output logic [31:0] io_resp_rdata,
  output logic [31:0] io_mem_addr,
  output logic        io_mem_read,
  output logic        io_mem_write,
  output logic [31:0] io_mem_dataIn,
  input  logic [31:0] io_mem_dataOut
);

  lsu_state_e        state_q, state_d, route;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       load_data;
  logic              resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic              req_fire, is_ld, is_st, aligned;
  logic              unused_addr_hi;

  // memory wraps at 2^MEM_AW words, higher address bits are dropped
  assign unused_addr_hi = ^io_req_addr[31:MEM_AW+2];

  assign io_req_ready = (state_q == ST_IDLE);
  assign req_fire     = io_req_valid & io_req_ready;
  assign is_ld        = io_req_load & ~io_req_store;
  assign is_st        = io_req_store & ~io_req_load;
  assign aligned      = addr_aligned(io_req_funct3[1:0], io_req_addr[1:0]);

  always_comb begin
    route = ST_ERR;
    if (is_ld && f3_load_ok(io_req_funct3) && aligned) begin
      route = ST_RD;
    end else if (is_st && aligned) begin
      case (io_req_funct3)
        F3_W:       route = ST_WR;
        F3_B, F3_H: route = ST_RMW_RD;
        default:    route = ST_ERR;
      endcase
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = req_fire ? route : ST_IDLE;
      ST_RMW_RD: state_d = ST_RMW_WR;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    merge_d = io_mem_dataOut;
    if (f3_q[1:0] == SZ_H) begin
      merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  lsu_load_align u_align (
    .word    (io_mem_dataOut),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (load_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (req_fire) begin
        addr_q  <= io_req_addr[MEM_AW+1:0];
        wdata_q <= io_req_wdata;
        f3_q    <= io_req_funct3;
      end
      case (state_q)
        ST_RD: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
        end
        ST_WR, ST_RMW_WR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        ST_ERR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
        end
        ST_RMW_RD: merge_q <= merge_d;
        default: ;
      endcase
    end
  end

  // memory strobes decode straight from state so reset kills them at once
  assign io_mem_read   = (state_q == ST_RD) || (state_q == ST_RMW_RD);
  assign io_mem_write  = (state_q == ST_WR) || (state_q == ST_RMW_WR);
  assign io_mem_addr   = (state_q == ST_IDLE) ? 32'h0 :
                         {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
  assign io_mem_dataIn = (state_q == ST_WR)     ? wdata_q :
                         (state_q == ST_RMW_WR) ? merge_q : 32'h0;

  assign io_resp_valid = resp_valid_q;
  assign io_resp_err   = resp_err_q;
  assign io_resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, byte-level reference
// model, directed cases then randomized requests.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic        io_req_load = 1'b0;
  logic        io_req_store = 1'b0;
  logic [2:0]  io_req_funct3 = 3'b0;
  logic [31:0] io_req_addr = 32'h0;
  logic [31:0] io_req_wdata = 32'h0;
  logic        io_resp_valid;
  logic        io_resp_err;
  logic [31:0] io_resp_rdata;
  logic [31:0] io_mem_addr;
  logic        io_mem_read;
  logic        io_mem_write;
  logic [31:0] io_mem_dataIn;
  logic [31:0] io_mem_dataOut;

  int n_err = 0;
  int n_checks = 0;

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];

  load_store_unit #(.MEM_AW(10)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_req_valid   (io_req_valid),
    .io_req_ready   (io_req_ready),
    .io_req_load    (io_req_load),
    .io_req_store   (io_req_store),
    .io_req_funct3  (io_req_funct3),
    .io_req_addr    (io_req_addr),
    .io_req_wdata   (io_req_wdata),
    .io_resp_valid  (io_resp_valid),
    .io_resp_err    (io_resp_err),
    .io_resp_rdata  (io_resp_rdata),
    .io_mem_addr    (io_mem_addr),
    .io_mem_read    (io_mem_read),
    .io_mem_write   (io_mem_write),
    .io_mem_dataIn  (io_mem_dataIn),
    .io_mem_dataOut (io_mem_dataOut)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (io_mem_write) dmem[io_mem_addr[9:0]] <= io_mem_dataIn;
  end
  assign io_mem_dataOut = io_mem_read ? dmem[io_mem_addr[9:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed view of the memory computed from the access rules.
  task automatic ref_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic e_err, output logic [31:0] e_rd,
                        output int e_lat, output int e_nr, output int e_nw,
                        output logic [31:0] e_wd);
    int sz, off, idx;
    logic legal;
    logic [31:0] w, v, mask;
    off = int'(a % 4);
    idx = int'((a / 4) % 1024);
    case (f3 % 4)
      0: sz = 1;
      1: sz = 2;
      2: sz = 4;
      default: sz = 0;
    endcase
    legal = (ld != st) && (sz != 0);
    if (legal) legal = (off % sz) == 0;
    if (legal) legal = ld ? (f3 != 3'b110) : (f3 < 3);
    e_err = !legal; e_rd = 0; e_lat = 2; e_nr = 0; e_nw = 0; e_wd = 0;
    w = ref_mem[idx];
    if (legal && ld) begin
      e_nr = 1;
      v = w >> (off * 8);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (f3 < 4 && v >= 128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (f3 < 4 && v >= 32768) v = v | 32'hFFFF_0000;
      end
      e_rd = v;
    end
    if (legal && st) begin
      e_nw = 1;
      if (sz == 4) begin
        e_wd = wd;
      end else begin
        e_nr = 1;
        e_lat = 3;
        mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << (off * 8);
        e_wd = (w & ~mask) | ((wd << (off * 8)) & mask);
      end
      ref_mem[idx] = e_wd;
    end
  endtask

  task automatic do_op(input string tag, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic e_err;
    logic [31:0] e_rd, e_wd, ra, wa, wdo, widx;
    int e_lat, e_nr, e_nw, lat, nr, nw, k;
    ref_op(ld, st, f3, a, wd, e_err, e_rd, e_lat, e_nr, e_nw, e_wd);
    widx = (a >> 2) & 32'd1023;
    @(negedge clock);
    k = 0;
    while (!io_req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!io_req_ready) chk({tag, "_ready_wait"}, 32'(io_req_ready), 32'd1);
    io_req_load = ld; io_req_store = st; io_req_funct3 = f3;
    io_req_addr = a; io_req_wdata = wd; io_req_valid = 1'b1;
    @(posedge clock); #1;
    io_req_valid = 1'b0;
    lat = 1; nr = 0; nw = 0; ra = 0; wa = 0; wdo = 0;
    while (!io_resp_valid && lat < 12) begin
      if (io_mem_read)  begin nr++; ra = io_mem_addr; end
      if (io_mem_write) begin nw++; wa = io_mem_addr; wdo = io_mem_dataIn; end
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(io_resp_err), 32'(e_err));
    chk({tag, "_rdata"}, io_resp_rdata, e_rd);
    chk({tag, "_nreads"}, 32'(nr), 32'(e_nr));
    chk({tag, "_nwrites"}, 32'(nw), 32'(e_nw));
    if (e_nr > 0) chk({tag, "_raddr"}, ra, widx);
    if (e_nw > 0) begin
      chk({tag, "_waddr"}, wa, widx);
      chk({tag, "_wdata"}, wdo, e_wd);
    end
    @(posedge clock); #1;
    chk({tag, "_pulse"}, 32'(io_resp_valid), 32'd0);
  endtask

  initial begin : main
    logic e_err;
    logic [31:0] e_rd, e_wd, b2b_rd;
    int e_lat, e_nr, e_nw;
    logic [31:0] ra;
    int r;

    #13;
    chk("rst_ready", 32'(io_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(io_resp_valid), 32'd0);
    chk("rst_err", 32'(io_resp_err), 32'd0);
    chk("rst_rdata", io_resp_rdata, 32'd0);
    chk("rst_mem_rd", 32'(io_mem_read), 32'd0);
    chk("rst_mem_wr", 32'(io_mem_write), 32'd0);
    chk("rst_mem_addr", io_mem_addr, 32'd0);
    chk("rst_dataIn", io_mem_dataIn, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    do_op("sw_w5",  1'b0, 1'b1, 3'b010, 32'h14, 32'h8899_AABB);
    do_op("lb_16",  1'b1, 1'b0, 3'b000, 32'h16, 32'h0);
    do_op("lbu_16", 1'b1, 1'b0, 3'b100, 32'h16, 32'h0);
    do_op("sw_20",  1'b0, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    do_op("lw_20",  1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    do_op("sb_21",  1'b0, 1'b1, 3'b000, 32'h21, 32'h12);
    do_op("sh_22",  1'b0, 1'b1, 3'b001, 32'h22, 32'h3456);
    do_op("lw_20b", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    do_op("lh_22",  1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    do_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    do_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h01, 32'h0);
    do_op("sw_f3_3", 1'b0, 1'b1, 3'b011, 32'h20, 32'h1111_2222);
    do_op("both",   1'b1, 1'b1, 3'b010, 32'h20, 32'h0);
    do_op("neither", 1'b0, 1'b0, 3'b010, 32'h20, 32'h0);
    do_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h23, 32'h5555);
    do_op("lw_wrap", 1'b1, 1'b0, 3'b010, 32'h0000_1020, 32'h0);

    // back-to-back: valid held through the response cycle
    @(negedge clock);
    io_req_load = 1'b0; io_req_store = 1'b1; io_req_funct3 = 3'b010;
    io_req_addr = 32'h30; io_req_wdata = 32'hCAFE_F00D; io_req_valid = 1'b1;
    ref_op(1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, e_err, e_rd, e_lat, e_nr, e_nw, e_wd);
    @(posedge clock);
    @(negedge clock);
    io_req_load = 1'b1; io_req_store = 1'b0;
    @(posedge clock); #1;
    chk("b2b_sw_resp", 32'(io_resp_valid), 32'd1);
    chk("b2b_sw_ready", 32'(io_req_ready), 32'd1);
    chk("b2b_sw_err", 32'(io_resp_err), 32'd0);
    @(posedge clock); #1;
    io_req_valid = 1'b0;
    chk("b2b_lw_accepted", 32'(io_mem_read), 32'd1);
    chk("b2b_lw_addr", io_mem_addr, 32'd12);
    ref_op(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, e_err, b2b_rd, e_lat, e_nr, e_nw, e_wd);
    @(posedge clock); #1;
    chk("b2b_lw_resp", 32'(io_resp_valid), 32'd1);
    chk("b2b_lw_rdata", io_resp_rdata, b2b_rd);

    // reset during the write half of a read-modify-write
    do_op("sw_24", 1'b0, 1'b1, 3'b010, 32'h24, 32'h0BAD_F00D);
    @(negedge clock);
    io_req_load = 1'b0; io_req_store = 1'b1; io_req_funct3 = 3'b000;
    io_req_addr = 32'h25; io_req_wdata = 32'h77; io_req_valid = 1'b1;
    @(posedge clock); #1;
    io_req_valid = 1'b0;
    @(posedge clock); #1;
    chk("rst_pre_write", 32'(io_mem_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_write_drop", 32'(io_mem_write), 32'd0);
    chk("rst_mid_ready", 32'(io_req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(io_req_ready), 32'd1);
    chk("rst_rel_resp", 32'(io_resp_valid), 32'd0);
    @(posedge clock); #1;
    chk("rst_rel_resp2", 32'(io_resp_valid), 32'd0);
    do_op("lw_24_kept", 1'b1, 1'b0, 3'b010, 32'h24, 32'h0);

    // fill words 0..15, then random traffic over them
    for (int i = 0; i < 16; i++) begin
      do_op("fill", 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom);
    end
    for (int i = 0; i < 60; i++) begin
      logic ld, st;
      r = $urandom_range(0, 9);
      ld = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
      st = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : ~r[0];
      ra = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
      do_op("rand", ld, st, 3'($urandom_range(0, 7)), ra, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
